// File: rtl/vga_timing_gen_if.sv
// Pixel-stream interface carrying raster timing and colour from the timing
// generator (master, source end) to the gamma stage (slave, sink end).
//   vga_vsync  vertical sync, polarity set by the source
//   vga_hsync  horizontal sync, polarity set by the source
//   vga_de     data enable, high during visible pixels
//   vga_r/g/b  8-bit colour components, zero outside vga_de
interface vga_timing_gen_if;
  logic       vga_vsync;
  logic       vga_hsync;
  logic       vga_de;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;

  modport master (output vga_vsync, vga_hsync, vga_de, vga_r, vga_g, vga_b);
  modport slave  (input  vga_vsync, vga_hsync, vga_de, vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: produces hsync/vsync/de for one video mode, pulls
// one pixel per active slot from the frame-buffer read FIFO, offers a
// colour-bar pattern for bring-up and flags FIFO underflow (sticky).
// Ports:
//   sclk, s_rst      pixel clock, asynchronous active-high reset
//   i_pattern_en     select colour bars (taken at frame start only)
//   o_data_req       FIFO read strobe, one per active pixel in data mode
//   o_x, o_y         active pixel coordinate aligned with o_data_req
//   o_frame_start    one-cycle pulse at the start of each frame
//   i_rgb            {r,g,b} from the FIFO, one cycle after o_data_req
//   i_data_valid     FIFO data valid, same timing as i_rgb
//   o_underflow      sticky: a requested pixel arrived without valid
//   vga              pixel-stream source (syncs, de, colour)
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             i_pattern_en,
  output logic             o_data_req,
  output logic [10:0]      o_x,
  output logic [9:0]       o_y,
  output logic             o_frame_start,
  input  logic [23:0]      i_rgb,
  input  logic             i_data_valid,
  output logic             o_underflow,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_START_C = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_END_C   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_START_C = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_END_C   = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [HW-1:0] BAR_LAST  = HW'(BAR_W - 1);
  localparam bit            SYNC_IDLE = ~SYNC_POL;

  function automatic logic sync_level(input logic asserted);
    sync_level = asserted ? SYNC_POL : SYNC_IDLE;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0: bar_colour = 24'hFFFFFF;
      3'd1: bar_colour = 24'hFFFF00;
      3'd2: bar_colour = 24'h00FFFF;
      3'd3: bar_colour = 24'h00FF00;
      3'd4: bar_colour = 24'hFF00FF;
      3'd5: bar_colour = 24'hFF0000;
      3'd6: bar_colour = 24'h0000FF;
      3'd7: bar_colour = 24'h000000;
    endcase
  endfunction

  // A missing FIFO word is shown black rather than repeating stale data.
  function automatic logic [23:0] pixel_sel(input logic vld, input logic pat,
                                            input logic data_ok,
                                            input logic [2:0] bar,
                                            input logic [23:0] rgb);
    if (!vld)         pixel_sel = 24'h000000;
    else if (pat)     pixel_sel = bar_colour(bar);
    else if (data_ok) pixel_sel = rgb;
    else              pixel_sel = 24'h000000;
  endfunction

  logic [HW-1:0] h_cnt_p0;
  logic [VW-1:0] v_cnt_p0;
  logic          pat_mode;
  logic [HW-1:0] bar_px;
  logic [2:0]    bar_sel;
  logic          at_origin_p0, active_p0, hs_p0, vs_p0;

  logic          vld_p1, pat_p1, hs_p1, vs_p1;
  logic [2:0]    bar_p1;
  logic          vld_p2, pat_p2, hs_p2, vs_p2;
  logic [2:0]    bar_p2;

  // ---- stage 0: raster counters and region decode ----
  always_comb begin
    at_origin_p0 = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
    active_p0    = (h_cnt_p0 >= H_START_C) && (h_cnt_p0 < H_END_C) &&
                   (v_cnt_p0 >= V_START_C) && (v_cnt_p0 < V_END_C);
    hs_p0        = (h_cnt_p0 < H_SYNC_C);
    vs_p0        = (v_cnt_p0 < V_SYNC_C);
  end

  // Bars come from a pixel counter that restarts on every active run, so no
  // divider is needed to find the bar index of a column.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
      pat_mode <= 1'b0;
      bar_px   <= '0;
      bar_sel  <= '0;
    end else begin
      if (h_cnt_p0 == H_LAST) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 1'b1;
      end else begin
        h_cnt_p0 <= h_cnt_p0 + 1'b1;
      end
      // Mode is frozen for a whole frame so a frame never mixes sources.
      if (at_origin_p0) pat_mode <= i_pattern_en;
      if (active_p0) begin
        if (bar_px == BAR_LAST) begin
          bar_px  <= '0;
          bar_sel <= bar_sel + 1'b1;
        end else begin
          bar_px <= bar_px + 1'b1;
        end
      end else begin
        bar_px  <= '0;
        bar_sel <= '0;
      end
    end
  end

  // ---- stage 1: registered decode, FIFO request and coordinates ----
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      vld_p1        <= 1'b0;
      pat_p1        <= 1'b0;
      bar_p1        <= '0;
      hs_p1         <= SYNC_IDLE;
      vs_p1         <= SYNC_IDLE;
      o_data_req    <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      vld_p1        <= active_p0;
      pat_p1        <= pat_mode;
      bar_p1        <= bar_sel;
      hs_p1         <= sync_level(hs_p0);
      vs_p1         <= sync_level(vs_p0);
      o_data_req    <= active_p0 & ~pat_mode;
      o_x           <= active_p0 ? 11'(h_cnt_p0 - H_START_C) : 11'd0;
      o_y           <= active_p0 ? 10'(v_cnt_p0 - V_START_C) : 10'd0;
      o_frame_start <= at_origin_p0;
    end
  end

  // ---- stage 2: wait for the FIFO word requested in stage 1 ----
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      vld_p2 <= 1'b0;
      pat_p2 <= 1'b0;
      bar_p2 <= '0;
      hs_p2  <= SYNC_IDLE;
      vs_p2  <= SYNC_IDLE;
    end else begin
      vld_p2 <= vld_p1;
      pat_p2 <= pat_p1;
      bar_p2 <= bar_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  // ---- stage 3: output register, FIFO word sampled here ----
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      vga.vga_de                         <= 1'b0;
      vga.vga_hsync                      <= SYNC_IDLE;
      vga.vga_vsync                      <= SYNC_IDLE;
      {vga.vga_r, vga.vga_g, vga.vga_b}  <= 24'h000000;
      o_underflow                        <= 1'b0;
    end else begin
      vga.vga_de                         <= vld_p2;
      vga.vga_hsync                      <= hs_p2;
      vga.vga_vsync                      <= vs_p2;
      {vga.vga_r, vga.vga_g, vga.vga_b}  <= pixel_sel(vld_p2, pat_p2, i_data_valid,
                                                      bar_p2, i_rgb);
      if (vld_p2 && !pat_p2 && !i_data_valid) o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  // Reduced raster for the small instances: 28 x 13 counter cycles per frame.
  localparam int HT  = 28;
  localparam int VT  = 13;
  localparam int FT  = HT * VT;
  localparam int HST = 9;
  localparam int VST = 5;
  localparam int HA  = 16;
  localparam int VA  = 6;
  localparam int BW  = 2;

  logic sclk = 1'b0;
  logic s_rst;
  always #5 sclk = ~sclk;

  // default-parameter instance
  logic        big_pat, big_req, big_fs, big_valid, big_uf;
  logic [10:0] big_x;
  logic [9:0]  big_y;
  logic [23:0] big_rgb_in;
  vga_timing_gen_if vga_big();

  // small instances, active-high and active-low syncs, shared FIFO model
  logic        sm_pat, sm_req, sm_fs, sm_valid, sm_uf;
  logic [10:0] sm_x;
  logic [9:0]  sm_y;
  logic [23:0] sm_rgb_in;
  vga_timing_gen_if vga_sm();
  logic        ng_req, ng_fs, ng_uf;
  logic [10:0] ng_x;
  logic [9:0]  ng_y;
  vga_timing_gen_if vga_ng();

  vga_timing_gen u_big (
    .sclk(sclk), .s_rst(s_rst), .i_pattern_en(big_pat), .o_data_req(big_req),
    .o_x(big_x), .o_y(big_y), .o_frame_start(big_fs), .i_rgb(big_rgb_in),
    .i_data_valid(big_valid), .o_underflow(big_uf), .vga(vga_big)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_sm (
    .sclk(sclk), .s_rst(s_rst), .i_pattern_en(sm_pat), .o_data_req(sm_req),
    .o_x(sm_x), .o_y(sm_y), .o_frame_start(sm_fs), .i_rgb(sm_rgb_in),
    .i_data_valid(sm_valid), .o_underflow(sm_uf), .vga(vga_sm)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_ng (
    .sclk(sclk), .s_rst(s_rst), .i_pattern_en(sm_pat), .o_data_req(ng_req),
    .o_x(ng_x), .o_y(ng_y), .o_frame_start(ng_fs), .i_rgb(sm_rgb_in),
    .i_data_valid(sm_valid), .o_underflow(ng_uf), .vga(vga_ng)
  );

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;
  int drop_k = -1;
  bit drop_en = 1'b0;
  bit pat_model = 1'b0;
  bit uf_model = 1'b0;
  logic        cap_req;
  logic [10:0] cap_x;
  logic [9:0]  cap_y;
  logic [23:0] bars [8];
  int first_req, first_de, de_cnt, req_cnt;
  logic [10:0] fr_x;
  logic [9:0]  fr_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Advance one pixel clock; FIFO model answers each request one cycle later.
  task automatic tick();
    cap_req = sm_req;
    cap_x   = sm_x;
    cap_y   = sm_y;
    if (k % FT == 0) pat_model = sm_pat;
    @(posedge sclk);
    #1;
    k++;
    sm_rgb_in = cap_req ? {cap_x[7:0], cap_y[7:0], 8'hA5} : 24'h5A5A5A;
    sm_valid  = cap_req;
    if (cap_req && drop_en && cap_x == 11'd3 && cap_y == 10'd2) begin
      sm_valid = 1'b0;
      drop_en  = 1'b0;
      drop_k   = k + 1;
    end
  endtask

  task automatic check_reset_small(input string tag);
    chk({tag, "_req"}, 32'(sm_req), 32'd0);
    chk({tag, "_x"}, 32'(sm_x), 32'd0);
    chk({tag, "_y"}, 32'(sm_y), 32'd0);
    chk({tag, "_fs"}, 32'(sm_fs), 32'd0);
    chk({tag, "_de"}, 32'(vga_sm.vga_de), 32'd0);
    chk({tag, "_hs"}, 32'(vga_sm.vga_hsync), 32'd0);
    chk({tag, "_vs"}, 32'(vga_sm.vga_vsync), 32'd0);
    chk({tag, "_rgb"}, 32'({vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'd0);
    chk({tag, "_uf"}, 32'(sm_uf), 32'd0);
    chk({tag, "_ng_hs"}, 32'(vga_ng.vga_hsync), 32'd1);
    chk({tag, "_ng_vs"}, 32'(vga_ng.vga_vsync), 32'd1);
    chk({tag, "_ng_req"}, 32'(ng_req), 32'd0);
  endtask

  // Reference raster computed from cycles since reset release.
  task automatic check_small();
    int c, hc, vc;
    bit act1, org1, act3, hs3, vs3;
    logic [10:0] ex;
    logic [9:0]  ey;
    logic [23:0] exp_rgb;
    act1 = 1'b0; org1 = 1'b0; ex = '0; ey = '0;
    if (k >= 1) begin
      c = k - 1; hc = c % HT; vc = (c / HT) % VT;
      act1 = (hc >= HST) && (hc < HST + HA) && (vc >= VST) && (vc < VST + VA);
      org1 = (hc == 0) && (vc == 0);
      if (act1) begin
        ex = 11'(hc - HST);
        ey = 10'(vc - VST);
      end
    end
    chk("req", 32'(sm_req), 32'(act1 && !pat_model));
    chk("x", 32'(sm_x), 32'(ex));
    chk("y", 32'(sm_y), 32'(ey));
    chk("fs", 32'(sm_fs), 32'(org1));
    chk("ng_req", 32'(ng_req), 32'(act1 && !pat_model));
    chk("ng_x", 32'(ng_x), 32'(ex));
    chk("ng_y", 32'(ng_y), 32'(ey));
    chk("ng_fs", 32'(ng_fs), 32'(org1));
    act3 = 1'b0; hs3 = 1'b0; vs3 = 1'b0; exp_rgb = '0;
    if (k >= 3) begin
      c = k - 3; hc = c % HT; vc = (c / HT) % VT;
      act3 = (hc >= HST) && (hc < HST + HA) && (vc >= VST) && (vc < VST + VA);
      hs3 = (hc < 4);
      vs3 = (vc < 2);
      if (act3) begin
        if (pat_model) exp_rgb = bars[(hc - HST) / BW];
        else if (k == drop_k) begin
          exp_rgb  = 24'h000000;
          uf_model = 1'b1;
        end else exp_rgb = {8'(hc - HST), 8'(vc - VST), 8'hA5};
      end
    end
    chk("de", 32'(vga_sm.vga_de), 32'(act3));
    chk("hs", 32'(vga_sm.vga_hsync), 32'(hs3));
    chk("vs", 32'(vga_sm.vga_vsync), 32'(vs3));
    chk("rgb", 32'({vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'(exp_rgb));
    chk("uf", 32'(sm_uf), 32'(uf_model));
    chk("ng_hs", 32'(vga_ng.vga_hsync), 32'(!hs3));
    chk("ng_vs", 32'(vga_ng.vga_vsync), 32'(!vs3));
    chk("ng_de", 32'(vga_ng.vga_de), 32'(act3));
    chk("ng_rgb", 32'({vga_ng.vga_r, vga_ng.vga_g, vga_ng.vga_b}), 32'(exp_rgb));
    chk("ng_uf", 32'(ng_uf), 32'(uf_model));
  endtask

  task automatic release_reset();
    @(negedge sclk);
    s_rst = 1'b0;
    k = 0;
    pat_model = 1'b0;
    uf_model = 1'b0;
    drop_k = -1;
    drop_en = 1'b0;
    sm_valid = 1'b0;
    sm_rgb_in = 24'h5A5A5A;
    #1;
  endtask

  initial begin
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    s_rst = 1'b1;
    big_pat = 1'b0; big_valid = 1'b1; big_rgb_in = 24'h000000;
    sm_pat = 1'b0; sm_valid = 1'b0; sm_rgb_in = 24'h5A5A5A;

    // Reset state, default instance and small instances.
    repeat (3) @(posedge sclk);
    #1;
    chk("big_rst_req", 32'(big_req), 32'd0);
    chk("big_rst_de", 32'(vga_big.vga_de), 32'd0);
    chk("big_rst_hs", 32'(vga_big.vga_hsync), 32'd0);
    chk("big_rst_vs", 32'(vga_big.vga_vsync), 32'd0);
    chk("big_rst_rgb", 32'({vga_big.vga_r, vga_big.vga_g, vga_big.vga_b}), 32'd0);
    chk("big_rst_uf", 32'(big_uf), 32'd0);
    chk("big_rst_xy", 32'({big_x, big_y}), 32'd0);
    chk("big_rst_fs", 32'(big_fs), 32'd0);
    check_reset_small("rst0");

    // Default 1280x720 timing from reset release.
    release_reset();
    first_req = -1; first_de = -1; fr_x = '1; fr_y = '1;
    while (k < 41520) begin
      if (big_req && first_req < 0) begin
        first_req = k; fr_x = big_x; fr_y = big_y;
      end
      if (vga_big.vga_de && first_de < 0) begin
        first_de = k;
        chk("big_first_rgb", 32'({vga_big.vga_r, vga_big.vga_g, vga_big.vga_b}), 32'd0);
      end
      case (k)
        0:    chk("big_fs_k0", 32'(big_fs), 32'd0);
        1:    chk("big_fs_k1", 32'(big_fs), 32'd1);
        2:    begin chk("big_fs_k2", 32'(big_fs), 32'd0); chk("big_hs_k2", 32'(vga_big.vga_hsync), 32'd0); end
        3:    begin chk("big_hs_k3", 32'(vga_big.vga_hsync), 32'd1); chk("big_vs_k3", 32'(vga_big.vga_vsync), 32'd1); end
        42:   chk("big_hs_k42", 32'(vga_big.vga_hsync), 32'd1);
        43:   chk("big_hs_k43", 32'(vga_big.vga_hsync), 32'd0);
        1652: chk("big_hs_k1652", 32'(vga_big.vga_hsync), 32'd0);
        1653: chk("big_hs_k1653", 32'(vga_big.vga_hsync), 32'd1);
        1692: chk("big_hs_k1692", 32'(vga_big.vga_hsync), 32'd1);
        1693: chk("big_hs_k1693", 32'(vga_big.vga_hsync), 32'd0);
        8252: chk("big_vs_k8252", 32'(vga_big.vga_vsync), 32'd1);
        8253: chk("big_vs_k8253", 32'(vga_big.vga_vsync), 32'd0);
        default: ;
      endcase
      tick();
    end
    chk("big_first_req", 32'(first_req), 32'd41511);
    chk("big_first_de", 32'(first_de), 32'd41513);
    chk("big_first_x", 32'(fr_x), 32'd0);
    chk("big_first_y", 32'(fr_y), 32'd0);

    // Asynchronous reset taken mid-cycle, then the reduced raster.
    #2;
    s_rst = 1'b1;
    #1;
    check_reset_small("arst");
    @(posedge sclk);
    #1;
    check_reset_small("arst_hold");
    release_reset();
    de_cnt = 0; req_cnt = 0;
    while (1) begin
      check_small();
      if (k >= 3 && k < 3 + FT && vga_sm.vga_de) de_cnt++;
      if (k >= FT * 2 + 1 && k < FT * 3 + 1 && sm_req) req_cnt++;
      case (k)
        3:    chk("d_hs_on", 32'(vga_sm.vga_hsync), 32'd1);
        7:    chk("d_hs_off", 32'(vga_sm.vga_hsync), 32'd0);
        58:   chk("d_vs_on", 32'(vga_sm.vga_vsync), 32'd1);
        59:   chk("d_vs_off", 32'(vga_sm.vga_vsync), 32'd0);
        149:  chk("d_req_before", 32'(sm_req), 32'd0);
        150:  chk("d_req_first", 32'({sm_req, sm_x, sm_y}), 32'({1'b1, 11'd0, 10'd0}));
        151:  chk("d_de_before", 32'(vga_sm.vga_de), 32'd0);
        152:  chk("d_de_first", 32'({vga_sm.vga_de, vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'h10000A5);
        367:  chk("d_de_per_frame", 32'(de_cnt), 32'd96);
        464:  drop_en = 1'b1;
        574:  chk("d_uf_before", 32'(sm_uf), 32'd0);
        575:  chk("d_drop_px", 32'({sm_uf, vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'h1000000);
        614:  sm_pat = 1'b1;
        654:  chk("d_req_mid_toggle", 32'(sm_req), 32'd1);
        880:  chk("d_bar0", 32'({vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'hFFFFFF);
        882:  chk("d_bar1", 32'({vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'hFFFF00);
        886:  chk("d_bar3", 32'({vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'h00FF00);
        893:  chk("d_bar6", 32'({vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'h0000FF);
        895:  chk("d_bar7", 32'({vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'h000000);
        1000: sm_pat = 1'b0;
        1005: chk("d_bar_hold", 32'({vga_sm.vga_r, vga_sm.vga_g, vga_sm.vga_b}), 32'h0000FF);
        1093: chk("d_req_pat_frame", 32'(req_cnt), 32'd0);
        1300: chk("d_uf_sticky", 32'(sm_uf), 32'd1);
        1330: chk("d_req_pre_rst", 32'(sm_req), 32'd1);
        default: ;
      endcase
      if (k == 1330) break;
      tick();
    end

    // Reset in the middle of an active line.
    #2;
    s_rst = 1'b1;
    #1;
    check_reset_small("mrst");
    @(posedge sclk);
    #1;
    check_reset_small("mrst_hold");
    release_reset();
    while (k <= 400) begin
      check_small();
      case (k)
        3:   chk("r_hs_on", 32'(vga_sm.vga_hsync), 32'd1);
        7:   chk("r_hs_off", 32'(vga_sm.vga_hsync), 32'd0);
        59:  chk("r_vs_off", 32'(vga_sm.vga_vsync), 32'd0);
        150: chk("r_req_first", 32'(sm_req), 32'd1);
        default: ;
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
